// File: rtl/alt_mem_ddrx_wdata_cmd_scheduler.sv
// ============================================================================
// alt_mem_ddrx_wdata_cmd_scheduler: holds write commands until enough data
// beats are buffered, then issues them in order.  Rev 1.0
// ============================================================================
`default_nettype none

module alt_mem_ddrx_wdata_cmd_scheduler #(
   parameter int CFG_BURSTCOUNT_TRACKING_WIDTH = 7,
   parameter int CFG_INT_SIZE_WIDTH            = 4,
   parameter int CFG_CMD_ID_WIDTH              = 4,
   parameter int CFG_CMD_FIFO_DEPTH            = 4
) (
   input  logic                                     ctl_clk,
   input  logic                                     ctl_reset,
   input  logic                                     cmd_valid,
   output logic                                     cmd_ready,
   input  logic [CFG_INT_SIZE_WIDTH-1:0]            cmd_size,
   input  logic [CFG_CMD_ID_WIDTH-1:0]              cmd_id,
   input  logic                                     burst_valid,
   output logic                                     burst_ready,
   output logic                                     issue_valid,
   input  logic                                     issue_ready,
   output logic [CFG_INT_SIZE_WIDTH-1:0]            issue_size,
   output logic [CFG_CMD_ID_WIDTH-1:0]              issue_id,
   output logic [CFG_BURSTCOUNT_TRACKING_WIDTH-1:0] data_pending_count,
   output logic [$clog2(CFG_CMD_FIFO_DEPTH):0]      cmd_fifo_count,
   output logic                                     err_zero_size
);

   localparam int PTR_W = $clog2(CFG_CMD_FIFO_DEPTH);
   localparam int CNT_W = CFG_BURSTCOUNT_TRACKING_WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(CFG_CMD_FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT_DATA, ISSUE} state_t;

   state_t state, state_next;

   logic [CFG_INT_SIZE_WIDTH-1:0] size_mem [CFG_CMD_FIFO_DEPTH];
   logic [CFG_CMD_ID_WIDTH-1:0]   id_mem   [CFG_CMD_FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr, rd_ptr;

   logic             cmd_accept, push, pop, beat_accept, fifo_empty, data_ok;
   logic [CNT_W-1:0] head_size_ext;

   assign cmd_ready     = (cmd_fifo_count != FIFO_FULL);
   assign cmd_accept    = cmd_valid & cmd_ready;
   // Zero-size commands are handshaken but never occupy a queue slot.
   assign push          = cmd_accept & (cmd_size != '0);
   assign pop           = (state == ISSUE) & issue_ready;
   assign burst_ready   = (data_pending_count != CNT_MAX);
   assign beat_accept   = burst_valid & burst_ready;
   assign fifo_empty    = (cmd_fifo_count == '0);
   assign issue_size    = size_mem[rd_ptr];
   assign issue_id      = id_mem[rd_ptr];
   assign head_size_ext = CNT_W'(issue_size);
   assign data_ok       = (data_pending_count >= head_size_ext);

   always_ff @(posedge ctl_clk) begin
      if (push) begin
         size_mem[wr_ptr] <= cmd_size;
         id_mem[wr_ptr]   <= cmd_id;
      end
   end

   always_ff @(posedge ctl_clk) begin
      if (ctl_reset) begin
         state              <= IDLE;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         cmd_fifo_count     <= '0;
         data_pending_count <= '0;
         err_zero_size      <= 1'b0;
      end else begin
         state <= state_next;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cmd_fifo_count <= cmd_fifo_count + 1'b1;
            2'b01:   cmd_fifo_count <= cmd_fifo_count - 1'b1;
            default: cmd_fifo_count <= cmd_fifo_count;
         endcase
         // ISSUE is only entered with count >= head size, so this cannot underflow.
         data_pending_count <= data_pending_count + CNT_W'(beat_accept)
                               - (pop ? head_size_ext : '0);
         if (cmd_accept && (cmd_size == '0)) err_zero_size <= 1'b1;
      end
   end

   always_comb begin
      state_next  = state;
      issue_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_next = data_ok ? ISSUE : WAIT_DATA;
         end
         WAIT_DATA: begin
            if (data_ok) state_next = ISSUE;
         end
         ISSUE: begin
            issue_valid = 1'b1;
            if (issue_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_alt_mem_ddrx_wdata_cmd_scheduler.sv
// ============================================================================
// tb_alt_mem_ddrx_wdata_cmd_scheduler: scoreboard bench for the write-data
// command scheduler.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_alt_mem_ddrx_wdata_cmd_scheduler;

   logic       ctl_clk = 1'b0;
   logic       ctl_reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_size = '0;
   logic [3:0] cmd_id = '0;
   logic       burst_valid = 1'b0;
   logic       burst_ready;
   logic       issue_valid;
   logic       issue_ready = 1'b0;
   logic [3:0] issue_size;
   logic [3:0] issue_id;
   logic [6:0] data_pending_count;
   logic [2:0] cmd_fifo_count;
   logic       err_zero_size;

   alt_mem_ddrx_wdata_cmd_scheduler dut (
      .ctl_clk            (ctl_clk),
      .ctl_reset          (ctl_reset),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_size           (cmd_size),
      .cmd_id             (cmd_id),
      .burst_valid        (burst_valid),
      .burst_ready        (burst_ready),
      .issue_valid        (issue_valid),
      .issue_ready        (issue_ready),
      .issue_size         (issue_size),
      .issue_id           (issue_id),
      .data_pending_count (data_pending_count),
      .cmd_fifo_count     (cmd_fifo_count),
      .err_zero_size      (err_zero_size)
   );

   always #5 ctl_clk = ~ctl_clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_issued = 0;
   int cyc = 0;
   int last_rise = -1;
   logic prev_iv = 1'b0;
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge ctl_clk) cyc <= cyc + 1;

   // Issue monitor: pops the scoreboard on every handshake seen mid-cycle.
   always @(negedge ctl_clk) begin
      if (!ctl_reset && issue_valid && !prev_iv) begin
         if (last_rise >= 0) check("issue_gap_ge2", 32'(cyc - last_rise >= 2), 1);
         last_rise = cyc;
      end
      prev_iv = issue_valid;
      if (!ctl_reset && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", 1, 0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("issue_size", 32'(issue_size), 32'(e[7:4]));
            check("issue_id", 32'(issue_id), 32'(e[3:0]));
            n_issued++;
         end
      end
   end

   task automatic tick();
      @(posedge ctl_clk);
      #1;
   endtask

   task automatic do_reset();
      ctl_reset = 1'b1;
      tick();
      ctl_reset = 1'b0;
      exp_q.delete();
      prev_iv = 1'b0;
      last_rise = -1;
   endtask

   task automatic push_cmd(input logic [3:0] sz, input logic [3:0] id);
      check("cmd_ready_before_push", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_size  = sz;
      cmd_id    = id;
      if (sz != 0) exp_q.push_back({sz, id});
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic beats(input int n);
      burst_valid = 1'b1;
      repeat (n) tick();
      burst_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      ctl_reset = 1'b0;
      tick();
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_burst_ready", 32'(burst_ready), 1);
      check("rst_count", 32'(data_pending_count), 0);
      check("rst_fifo", 32'(cmd_fifo_count), 0);
      check("rst_err", 32'(err_zero_size), 0);
      check("rst_issue_valid", 32'(issue_valid), 0);

      // Command waits for four beats, then issues one cycle after count hits 4
      issue_ready = 1'b1;
      push_cmd(4'd4, 4'd1);
      check("t1_fifo", 32'(cmd_fifo_count), 1);
      beats(4);
      check("t1_count4", 32'(data_pending_count), 4);
      check("t1_wait_no_issue", 32'(issue_valid), 0);
      tick();
      check("t1_issue_valid", 32'(issue_valid), 1);
      check("t1_issue_size", 32'(issue_size), 4);
      tick();
      check("t1_count0", 32'(data_pending_count), 0);
      check("t1_fifo0", 32'(cmd_fifo_count), 0);
      check("t1_issue_low", 32'(issue_valid), 0);

      // Two size-3 commands drain six buffered beats in order
      beats(6);
      check("t2_count6", 32'(data_pending_count), 6);
      push_cmd(4'd3, 4'd2);
      push_cmd(4'd3, 4'd3);
      check("t2_first_valid", 32'(issue_valid), 1);
      check("t2_first_id", 32'(issue_id), 2);
      check("t2_fifo2", 32'(cmd_fifo_count), 2);
      tick();
      check("t2_count3", 32'(data_pending_count), 3);
      check("t2_idle_gap", 32'(issue_valid), 0);
      tick();
      check("t2_second_valid", 32'(issue_valid), 1);
      check("t2_second_id", 32'(issue_id), 3);
      tick();
      check("t2_count0", 32'(data_pending_count), 0);

      // Stalled issue holds size/id; pop with same-cycle beat: 7 -> 3
      issue_ready = 1'b0;
      beats(7);
      push_cmd(4'd5, 4'd4);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_valid", 32'(issue_valid), 1);
         check("t3_hold_size", 32'(issue_size), 5);
         check("t3_hold_id", 32'(issue_id), 4);
         tick();
      end
      check("t3_count7", 32'(data_pending_count), 7);
      issue_ready = 1'b1;
      burst_valid = 1'b1;
      tick();
      burst_valid = 1'b0;
      check("t3_count3", 32'(data_pending_count), 3);
      check("t3_issue_low", 32'(issue_valid), 0);

      // Saturation: three beats already buffered, keep offering beyond 127
      beats(130);
      check("t4_sat_count", 32'(data_pending_count), 127);
      check("t4_sat_ready", 32'(burst_ready), 0);
      tick();
      check("t4_hold_count", 32'(data_pending_count), 127);
      push_cmd(4'd15, 4'd5);
      tick();
      check("t4_issue_valid", 32'(issue_valid), 1);
      tick();
      check("t4_count112", 32'(data_pending_count), 112);
      check("t4_ready_back", 32'(burst_ready), 1);

      // Full queue with no data, then zero-size command
      do_reset();
      tick();
      for (int i = 0; i < 4; i++) push_cmd(4'd8, 4'(6 + i));
      check("t5_cmd_ready_full", 32'(cmd_ready), 0);
      check("t5_fifo4", 32'(cmd_fifo_count), 4);
      check("t5_no_issue", 32'(issue_valid), 0);
      do_reset();
      tick();
      push_cmd(4'd0, 4'd10);
      check("t5_err_set", 32'(err_zero_size), 1);
      check("t5_no_entry", 32'(cmd_fifo_count), 0);

      // Reset while in ISSUE with three commands and nine beats
      issue_ready = 1'b0;
      beats(9);
      push_cmd(4'd5, 4'd1);
      push_cmd(4'd8, 4'd2);
      push_cmd(4'd8, 4'd3);
      check("t6_in_issue", 32'(issue_valid), 1);
      check("t6_fifo3", 32'(cmd_fifo_count), 3);
      check("t6_count9", 32'(data_pending_count), 9);
      do_reset();
      check("t6_issue_valid", 32'(issue_valid), 0);
      check("t6_fifo0", 32'(cmd_fifo_count), 0);
      check("t6_count0", 32'(data_pending_count), 0);
      check("t6_err0", 32'(err_zero_size), 0);
      check("t6_cmd_ready", 32'(cmd_ready), 1);
      check("t6_burst_ready", 32'(burst_ready), 1);
      tick();
      check("t6_stays_idle", 32'(issue_valid), 0);

      check("total_issues", 32'(n_issued), 5);
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
